pending_encoder: RTL and testbench

- 8-input request latch plus priority encoder with a valid/ready output handshake. It is the encode-side counterpart of the 3->8 decoder.
- Requests are captured into a sticky pending register. One index is presented at a time, highest index first, and held stable until a consumer accepts it.
- Sits between interrupt/request sources and the control unit, which consumes one 3-bit index per handshake.

---
 rtl/pending_encoder_pkg.sv | 20 ++
 rtl/pending_encoder_prio.sv | 29 ++
 rtl/pending_encoder.sv | 94 +++++++++
 tb/tb_pending_encoder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pending_encoder_pkg.sv
// Shared types and helpers for the pending request encoder.
// PENDING_ENCODER_ROUND_ROBIN_EN selects rotating priority in the top level.
package pending_encoder_pkg;

  localparam int N_DEFAULT = 8;
  localparam int MASK_W    = 32;

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  // One-hot clear mask; callers truncate to their own request width.
  function automatic logic [MASK_W-1:0] clr_mask(input logic [MASK_W-1:0] i);
    logic [MASK_W-1:0] one;
    one = 1;
    return one << i;
  endfunction

endpackage

// File: rtl/pending_encoder_prio.sv
// Combinational search: scans downward from start, wrapping from 0 to N-1,
// and reports the first set bit. Returns index 0 with found=0 on an empty vector.
module prio_pick #(
  parameter int N     = 8,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  input  logic [IDX_W-1:0] start,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] pos;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 0; k < N; k++) begin
      // N is a power of two, so index arithmetic wraps naturally
      pos = start - IDX_W'(k);
      if (!found && vec[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pending_encoder.sv
// Sticky request latch with priority-encoded index and valid/ready handshake.
// Define PENDING_ENCODER_ROUND_ROBIN_EN for rotating priority after each grant.
//
// state   | meaning
// IDLE    | nothing presented; picks from pend when non-empty
// PRESENT | idx held stable with valid=1 until ready
module pending_encoder
  import pending_encoder_pkg::*;
#(
  parameter int N = N_DEFAULT,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             n_ei,
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid,
  input  logic             ready,
  output logic [N-1:0]     pend,
  output logic             any
);

  state_t           state_q, state_d;
  logic             load, accept;
  logic [N-1:0]     pend_q, pend_d, clr;
  logic [IDX_W-1:0] idx_q, pick_idx, start;
  logic             found, any_q;

`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last_q;

  assign start = last_q - IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_q <= '0;
    else if (accept) last_q <= idx_q;
  end
`else
  assign start = IDX_W'(N - 1);
`endif

  prio_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .vec   (pend_q),
    .start (start),
    .idx   (pick_idx),
    .found (found)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = PRESENT;
          load    = 1'b1;
        end
      end
      PRESENT: begin
        if (ready) begin
          state_d = IDLE;
          accept  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A new request on the bit being cleared wins, keeping it pending
  assign clr    = accept ? N'(clr_mask(32'(idx_q))) : '0;
  assign pend_d = (pend_q & ~clr) | (n_ei ? '0 : req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      any_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      any_q   <= |pend_d;
      if (load) idx_q <= pick_idx;
    end
  end

  assign idx   = idx_q;
  assign valid = (state_q == PRESENT);
  assign pend  = pend_q;
  assign any   = any_q;

endmodule

// File: tb/tb_pending_encoder.sv
// Self-checking bench for pending_encoder against a cycle-level reference model.
module tb_pending_encoder;

  logic       clk = 1'b0;
  logic       rst_n, n_ei, ready;
  logic [7:0] req;
  wire  [2:0] idx;
  wire        valid;
  wire  [7:0] pend;
  wire        any;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_pend;
  logic       m_valid, m_any;
  logic [2:0] m_idx, m_last;

  always #5 clk = ~clk;

  pending_encoder dut (
    .clk(clk), .rst_n(rst_n), .n_ei(n_ei), .req(req), .idx(idx),
    .valid(valid), .ready(ready), .pend(pend), .any(any)
  );

  function automatic logic [2:0] m_pick(input logic [7:0] p, input logic [2:0] last);
    int i;
`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
    for (int s = 1; s <= 8; s++) begin
      i = (int'(last) + 8 - s) % 8;
      if (p[i]) return 3'(i);
    end
`else
    i = int'(last);
    for (int j = 7; j >= 0; j--) if (p[j]) return 3'(j);
`endif
    return 3'd0;
  endfunction

  task automatic model_reset();
    m_pend = 8'h00; m_valid = 1'b0; m_any = 1'b0; m_idx = 3'd0; m_last = 3'd0;
  endtask

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    logic       acc;
    logic [7:0] np;
    @(posedge clk);
    acc = m_valid && ready;
    np  = (m_pend & ~(acc ? (8'h01 << m_idx) : 8'h00)) | (n_ei ? 8'h00 : req);
    if (m_valid) begin
      if (ready) begin
        m_valid = 1'b0;
        m_last  = m_idx;
      end
    end else if (m_pend != 8'h00) begin
      m_idx   = m_pick(m_pend, m_last);
      m_valid = 1'b1;
    end
    m_pend = np;
    m_any  = (np != 8'h00);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; n_ei = 1'b0; ready = 1'b0; req = 8'h00;
    model_reset();
    #3;
    checks++;
    if ({valid, idx, pend, any} !== 13'h0) begin
      failures++;
      $display("FAIL reset_state got v=%b idx=%0d pend=%h any=%b want all zero", valid, idx, pend, any);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid();
    req = 8'h80; tick(); req = 8'h00; tick();
    checks++;
    if (valid !== 1'b1 || idx !== 3'd7) begin
      failures++;
      $display("FAIL rst_mid_grant got v=%b idx=%0d want v=1 idx=7", valid, idx);
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({valid, idx, pend, any} !== 13'h0) begin
      failures++;
      $display("FAIL rst_mid_async got v=%b idx=%0d pend=%h any=%b want all zero", valid, idx, pend, any);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (valid !== 1'b0 || pend !== 8'h00) begin
        failures++;
        $display("FAIL rst_mid_after got v=%b pend=%h want v=0 pend=00", valid, pend);
      end
    end
  endtask

  task automatic test_priority();
    logic [2:0] got[$];
    ready = 1'b1; req = 8'h25; tick(); req = 8'h00;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (valid === 1'b1) got.push_back(idx);
      checks++;
      if ({valid, idx, pend, any} !== {m_valid, m_idx, m_pend, m_any}) begin
        failures++;
        $display("FAIL prio_cycle%0d got v=%b idx=%0d pend=%h any=%b want v=%b idx=%0d pend=%h any=%b",
                 c, valid, idx, pend, any, m_valid, m_idx, m_pend, m_any);
      end
    end
    checks++;
    if (got.size() != 3 || got[0] !== 3'd5 || got[1] !== 3'd2 || got[2] !== 3'd0) begin
      failures++;
      $display("FAIL prio_sequence got %p want 5 2 0", got);
    end
    checks++;
    if (pend !== 8'h00 || any !== 1'b0) begin
      failures++;
      $display("FAIL prio_drained got pend=%h any=%b want 00 0", pend, any);
    end
    ready = 1'b0;
  endtask

  task automatic test_hold();
    ready = 1'b0; req = 8'h02; tick(); req = 8'h00;
    for (int c = 0; c < 7; c++) begin
      if (c >= 4) req = 8'h80;
      tick();
      checks++;
      if (valid !== 1'b1 || idx !== 3'd1 || valid !== m_valid || idx !== m_idx) begin
        failures++;
        $display("FAIL hold_cycle%0d got v=%b idx=%0d want v=1 idx=1", c, valid, idx);
      end
    end
    req = 8'h00; ready = 1'b1; tick(); ready = 1'b0; tick();
    checks++;
    if (valid !== 1'b1 || idx !== 3'd7) begin
      failures++;
      $display("FAIL hold_next got v=%b idx=%0d want v=1 idx=7", valid, idx);
    end
    ready = 1'b1; tick(); ready = 1'b0;
  endtask

  task automatic test_collision();
    req = 8'h08; tick(); req = 8'h00; tick();
    checks++;
    if (valid !== 1'b1 || idx !== 3'd3) begin
      failures++;
      $display("FAIL coll_present got v=%b idx=%0d want v=1 idx=3", valid, idx);
    end
    ready = 1'b1; req = 8'h08; tick(); ready = 1'b0; req = 8'h00;
    checks++;
    if (pend !== 8'h08 || valid !== 1'b0) begin
      failures++;
      $display("FAIL coll_setwins got pend=%h v=%b want pend=08 v=0", pend, valid);
    end
    tick();
    checks++;
    if (valid !== 1'b1 || idx !== 3'd3) begin
      failures++;
      $display("FAIL coll_represent got v=%b idx=%0d want v=1 idx=3", valid, idx);
    end
    ready = 1'b1; tick(); ready = 1'b0;
  endtask

  task automatic test_enable();
    n_ei = 1'b1; req = 8'hFF;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (pend !== 8'h00 || valid !== 1'b0) begin
        failures++;
        $display("FAIL en_gated got pend=%h v=%b want pend=00 v=0", pend, valid);
      end
    end
    n_ei = 1'b0; tick(); n_ei = 1'b1;
    checks++;
    if (pend !== 8'hFF || any !== 1'b1) begin
      failures++;
      $display("FAIL en_capture got pend=%h any=%b want FF 1", pend, any);
    end
    ready = 1'b1;
    for (int c = 0; c < 17; c++) begin
      tick();
      checks++;
      if ({valid, idx, pend, any} !== {m_valid, m_idx, m_pend, m_any}) begin
        failures++;
        $display("FAIL en_drain%0d got v=%b idx=%0d pend=%h want v=%b idx=%0d pend=%h",
                 c, valid, idx, pend, m_valid, m_idx, m_pend);
      end
    end
    checks++;
    if (pend !== 8'h00) begin
      failures++;
      $display("FAIL en_drained got pend=%h want 00", pend);
    end
    ready = 1'b0; n_ei = 1'b0; req = 8'h00;
  endtask

  task automatic test_rotation();
    logic [2:0] exp_seq[9];
    logic [2:0] got[$];
    for (int k = 0; k < 9; k++) begin
`ifdef PENDING_ENCODER_ROUND_ROBIN_EN
      exp_seq[k] = 3'((7 - k + 8) % 8);
`else
      exp_seq[k] = 3'd7;
`endif
    end
    #2 rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk);
    rst_n = 1'b1; req = 8'hFF; ready = 1'b1;
    for (int c = 0; c < 40 && got.size() < 9; c++) begin
      tick();
      if (valid === 1'b1) got.push_back(idx);
    end
    checks++;
    if (got.size() != 9) begin
      failures++;
      $display("FAIL rot_count got %0d grants want 9", got.size());
    end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== exp_seq[k]) begin
        failures++;
        $display("FAIL rot_grant%0d got %0d want %0d", k, got[k], exp_seq[k]);
      end
    end
    req = 8'h00; ready = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      req   = 8'($urandom_range(0, 255)) & ((c % 7 == 0) ? 8'hFF : 8'h00) |
              ((c % 5 == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00);
      n_ei  = ($urandom_range(0, 3) == 0);
      ready = ($urandom_range(0, 2) != 0);
      tick();
      checks++;
      if ({valid, idx, pend, any} !== {m_valid, m_idx, m_pend, m_any}) begin
        failures++;
        $display("FAIL rand%0d got v=%b idx=%0d pend=%h any=%b want v=%b idx=%0d pend=%h any=%b",
                 c, valid, idx, pend, any, m_valid, m_idx, m_pend, m_any);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_priority();
    test_hold();
    test_collision();
    test_enable();
    test_rotation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
